// File: rtl/skinny_inv_sbox_masked_pipe.sv
// Three-share masked inverse SKINNY-64 S-box, three-stage elastic pipeline.
// S^-1 = B3 o Q294 o B2 o Q294 o B1. The decomposition used here is
// S^-1 = G o rotr1 o G with the quadratic layer G(x) = N(rotr1(N(x))),
// where N flips bit 0 with NOR(bit3, bit2). B1 and B3 are the identity and
// B2 is a one-bit right rotation of the nibble.
// Each Q294 share function sees only two input shares plus fresh randomness.
// Shares are recombined only downstream of a register.
module skinny_inv_sbox_masked_pipe #(
    parameter bit RST_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in1,
    input  logic [3:0]  in2,
    input  logic [3:0]  in3,
    input  logic [23:0] r,
    input  logic [7:0]  rc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out1,
    output logic [3:0]  out2,
    output logic [3:0]  out3,
    output logic [1:0]  occupancy
);

    typedef struct packed {
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  s3;
        logic [23:0] r;
        logic [7:0]  rc;
    } st0_t;

    typedef struct packed {
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  s3;
        logic [11:0] r;
        logic [7:0]  rc;
    } st1_t;

    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] s3;
        logic [7:0] rc;
    } st2_t;

    // Input affine layer: identity in this decomposition.
    function automatic logic [3:0] b1_aff(input logic [3:0] x);
        return x;
    endfunction

    // Middle affine layer: rotate the nibble right by one bit.
    function automatic logic [3:0] b2_aff(input logic [3:0] x);
        return {x[0], x[3:1]};
    endfunction

    // Output affine layer: identity in this decomposition.
    function automatic logic [3:0] b3_aff(input logic [3:0] x);
        return x;
    endfunction

    // One share of G. p supplies the linear part, the cross terms pair p with q,
    // and 'one' injects the constant of G (set in exactly one share).
    // G: y3 = 1^a^b^d^ab, y2 = a, y1 = b, y0 = b^c^d^ab^ad with (a,b,c,d) = x[3:0].
    function automatic logic [3:0] g_share(input logic [3:0] p, input logic [3:0] q,
                                           input logic one);
        logic ab;
        logic ad;
        ab = (p[3] & p[2]) ^ (p[3] & q[2]) ^ (q[3] & p[2]);
        ad = (p[3] & p[0]) ^ (p[3] & q[0]) ^ (q[3] & p[0]);
        return {one ^ p[3] ^ p[2] ^ p[0] ^ ab, p[3], p[2], p[2] ^ p[1] ^ p[0] ^ ab ^ ad};
    endfunction

    // Shared quadratic layer. The pairs (1,2), (2,3), (3,1) together cover all
    // nine cross products; the ring of three random nibbles cancels in the sum.
    // Result is {share1, share2, share3}.
    function automatic logic [11:0] q294(input logic [3:0] x1, input logic [3:0] x2,
                                         input logic [3:0] x3, input logic [11:0] m);
        logic [3:0] f1;
        logic [3:0] f2;
        logic [3:0] f3;
        f1 = g_share(x1, x2, 1'b1) ^ m[3:0]  ^ m[7:4];
        f2 = g_share(x2, x3, 1'b0) ^ m[7:4]  ^ m[11:8];
        f3 = g_share(x3, x1, 1'b0) ^ m[11:8] ^ m[3:0];
        return {f1, f2, f3};
    endfunction

    logic  vld_p0, vld_p1, vld_p2;
    st0_t  data_p0, data_nxt_p0;
    st1_t  data_p1, data_nxt_p1;
    st2_t  data_p2, data_nxt_p2;
    logic  ok0, ok1, ok2, mv0, mv1, accept;
    logic [11:0] q_a, q_b;

    // Handshake: each stage may move when the stage ahead is empty or moving.
    always_comb begin
        ok2      = !vld_p2 | out_ready;
        mv1      = vld_p1 & ok2;
        ok1      = !vld_p1 | ok2;
        mv0      = vld_p0 & ok1;
        ok0      = !vld_p0 | ok1;
        in_ready = ok0 & !flush & rst_n;
        accept   = in_valid & in_ready;
    end

    // Next data for every stage: load on move, hold on stall, clear on flush.
    always_comb begin
        q_a = q294(data_p0.s1, data_p0.s2, data_p0.s3, data_p0.r[11:0]);
        q_b = q294(data_p1.s1, data_p1.s2, data_p1.s3, data_p1.r);

        data_nxt_p0 = data_p0;
        data_nxt_p1 = data_p1;
        data_nxt_p2 = data_p2;

        if (accept) begin
            data_nxt_p0.s1 = b1_aff(in1);
            data_nxt_p0.s2 = b1_aff(in2);
            data_nxt_p0.s3 = b1_aff(in3);
            data_nxt_p0.r  = r;
            data_nxt_p0.rc = rc;
        end
        if (mv0) begin
            data_nxt_p1.s1 = b2_aff(q_a[11:8]);
            data_nxt_p1.s2 = b2_aff(q_a[7:4]);
            data_nxt_p1.s3 = b2_aff(q_a[3:0]);
            data_nxt_p1.r  = data_p0.r[23:12];
            data_nxt_p1.rc = data_p0.rc;
        end
        if (mv1) begin
            data_nxt_p2.s1 = b3_aff(q_b[11:8]);
            data_nxt_p2.s2 = b3_aff(q_b[7:4]);
            data_nxt_p2.s3 = b3_aff(q_b[3:0]);
            data_nxt_p2.rc = data_p1.rc;
        end
        if (flush && RST_ZERO) begin
            data_nxt_p0 = '0;
            data_nxt_p1 = '0;
            data_nxt_p2 = '0;
        end
    end

    // Valid bits: flush wins over any transfer in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= accept | (vld_p0 & !mv0);
            vld_p1 <= mv0    | (vld_p1 & !mv1);
            vld_p2 <= mv1    | (vld_p2 & !out_ready);
        end
    end

    generate
        if (RST_ZERO) begin : g_data_rst
            // Data registers, cleared by reset so the outputs read zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_p0 <= '0;
                    data_p1 <= '0;
                    data_p2 <= '0;
                end else begin
                    data_p0 <= data_nxt_p0;
                    data_p1 <= data_nxt_p1;
                    data_p2 <= data_nxt_p2;
                end
            end
        end else begin : g_data_free
            // Data registers without reset; only the valid bits are cleared.
            always_ff @(posedge clk) begin
                data_p0 <= data_nxt_p0;
                data_p1 <= data_nxt_p1;
                data_p2 <= data_nxt_p2;
            end
        end
    endgenerate

    // Output remask with the rc captured alongside this datum; the sum is unchanged.
    always_comb begin
        out_valid = vld_p2;
        out1      = data_p2.s1 ^ data_p2.rc[3:0];
        out2      = data_p2.s2 ^ data_p2.rc[7:4];
        out3      = data_p2.s3 ^ data_p2.rc[3:0] ^ data_p2.rc[7:4];
        occupancy = {1'b0, vld_p0} + {1'b0, vld_p1} + {1'b0, vld_p2};
    end

endmodule
